// File: rtl/ws2812_frame_controller.sv
// Streams one frame of NUM_LEDS GRB pixels (MSB first) into the RZ encoder, then times the latch gap.
// TX is visible 3 edges after start; bits advance only on enc_cmd_wait handshakes; done ends the frame.
module ws2812_frame_controller #(
    parameter int CLK_FREQ_KHZ = 10000,
    parameter int NUM_LEDS     = 8,
    parameter int T_RESET_NS   = 80000,
    localparam int ADDR_WIDTH  = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] pix_addr,
    input  logic [23:0]           pix_data,
    output logic [1:0]            enc_cmd,
    output logic                  enc_databit,
    input  logic                  enc_cmd_wait
);
    localparam int CLK_PERIOD_NS = 1000000000 / (CLK_FREQ_KHZ * 1000);
    localparam int RESET_TICKS   = T_RESET_NS / CLK_PERIOD_NS;
    localparam int LCW           = $clog2(RESET_TICKS + 1);
    localparam logic [1:0] CMD_IDLE = 2'b00;
    localparam logic [1:0] CMD_TX   = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH_A, S_FETCH_D, S_SEND, S_DRAIN, S_LATCH
    } state_t;

    state_t                state_q, state_d;
    logic [23:0]           shift_q, shift_d;
    logic [23:0]           prefetch_q, prefetch_d;
    logic [4:0]            bit_idx_q, bit_idx_d;
    logic [ADDR_WIDTH-1:0] pix_idx_q, pix_idx_d;
    logic [ADDR_WIDTH-1:0] pix_addr_q, pix_addr_d;
    logic [LCW-1:0]        latch_cnt_q, latch_cnt_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [1:0]            enc_cmd_q, enc_cmd_d;
    logic                  enc_databit_q, enc_databit_d;
    logic                  consume;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        prefetch_d  = prefetch_q;
        bit_idx_d   = bit_idx_q;
        pix_idx_d   = pix_idx_q;
        pix_addr_d  = pix_addr_q;
        latch_cnt_d = latch_cnt_q;
        done_d      = 1'b0;
        consume     = enc_cmd_wait && (enc_cmd_q == CMD_TX);

        case (state_q)
            S_IDLE: begin
                pix_addr_d = '0;
                if (start) state_d = S_FETCH_A;
            end
            S_FETCH_A: state_d = S_FETCH_D;
            S_FETCH_D: begin
                shift_d    = pix_data;
                bit_idx_d  = 5'd23;
                pix_idx_d  = '0;
                pix_addr_d = (NUM_LEDS > 1) ? ADDR_WIDTH'(1) : '0;
                state_d    = S_SEND;
            end
            S_SEND: begin
                // RAM output tracks the address one pixel ahead; keep a copy for the pixel boundary
                prefetch_d = pix_data;
                if (consume) begin
                    if (bit_idx_q != 5'd0) begin
                        shift_d   = {shift_q[22:0], 1'b0};
                        bit_idx_d = bit_idx_q - 5'd1;
                    end else if (int'(pix_idx_q) < NUM_LEDS - 1) begin
                        shift_d   = prefetch_q;
                        bit_idx_d = 5'd23;
                        pix_idx_d = pix_idx_q + ADDR_WIDTH'(1);
                        if (int'(pix_idx_q) + 2 <= NUM_LEDS - 1)
                            pix_addr_d = pix_idx_q + ADDR_WIDTH'(2);
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (enc_cmd_wait) begin
                    latch_cnt_d = '0;
                    state_d     = S_LATCH;
                end
            end
            S_LATCH: begin
                // done is raised while still in LATCH so a start in the done cycle is ignored
                if (done_q) begin
                    state_d = S_IDLE;
                end else begin
                    if (latch_cnt_q != LCW'(RESET_TICKS)) latch_cnt_d = latch_cnt_q + LCW'(1);
                    if (latch_cnt_q == LCW'(RESET_TICKS - 1)) done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d        = (state_d != S_IDLE);
        enc_cmd_d     = (state_d == S_SEND) ? CMD_TX : CMD_IDLE;
        enc_databit_d = (state_d == S_SEND) ? shift_d[23] : 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            shift_q       <= '0;
            prefetch_q    <= '0;
            bit_idx_q     <= '0;
            pix_idx_q     <= '0;
            pix_addr_q    <= '0;
            latch_cnt_q   <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            enc_cmd_q     <= CMD_IDLE;
            enc_databit_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            prefetch_q    <= prefetch_d;
            bit_idx_q     <= bit_idx_d;
            pix_idx_q     <= pix_idx_d;
            pix_addr_q    <= pix_addr_d;
            latch_cnt_q   <= latch_cnt_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            enc_cmd_q     <= enc_cmd_d;
            enc_databit_q <= enc_databit_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign pix_addr    = pix_addr_q;
    assign enc_cmd     = enc_cmd_q;
    assign enc_databit = enc_databit_q;
endmodule

// File: tb/tb_ws2812_frame_controller.sv
// Bench: two controller instances (2 pixels and 1 pixel) each driving a behavioural RZ encoder and a registered RAM.
module tb_ws2812_frame_controller;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, mrst;
    logic st [2];
    logic clr [2];

    logic start0, busy0, done0, pa0, db0, wait0;
    logic start1, busy1, done1, pa1, db1, wait1;
    logic [1:0]  cmd0, cmd1;
    logic [23:0] pd0, pd1;

    logic a_busy [2], a_done [2], a_addr [2], a_db [2], a_wait [2], a_start [2];
    logic [1:0] a_cmd [2];

    logic e_act [2], e_bit [2];
    int   e_cnt [2];

    assign start0 = st[0];
    assign start1 = st[1];
    assign a_start[0] = st[0];  assign a_start[1] = st[1];
    assign a_busy[0] = busy0;   assign a_busy[1] = busy1;
    assign a_done[0] = done0;   assign a_done[1] = done1;
    assign a_addr[0] = pa0;     assign a_addr[1] = pa1;
    assign a_db[0]   = db0;     assign a_db[1]   = db1;
    assign a_cmd[0]  = cmd0;    assign a_cmd[1]  = cmd1;
    assign wait0 = !e_act[0] || (e_cnt[0] == 10);
    assign wait1 = !e_act[1] || (e_cnt[1] == 10);
    assign a_wait[0] = wait0;   assign a_wait[1] = wait1;

    ws2812_frame_controller #(.CLK_FREQ_KHZ(10000), .NUM_LEDS(2), .T_RESET_NS(80000)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .done(done0),
        .pix_addr(pa0), .pix_data(pd0), .enc_cmd(cmd0), .enc_databit(db0), .enc_cmd_wait(wait0));

    ws2812_frame_controller #(.CLK_FREQ_KHZ(10000), .NUM_LEDS(1), .T_RESET_NS(80000)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
        .pix_addr(pa1), .pix_data(pd1), .enc_cmd(cmd1), .enc_databit(db1), .enc_cmd_wait(wait1));

    logic [23:0] ram0 [2];
    logic [23:0] ram1;
    always @(posedge clk) begin
        pd0 <= ram0[pa0];
        pd1 <= ram1;
    end

    // encoder model (11-cycle bit, 7/3 high) plus per-frame statistics
    logic [63:0] cap [2];
    int nbits [2], last_cons [2], first_cons [2], sp_err [2], hi_err [2], hi_run [2];
    int done_cnt [2], last_fall [2], gap [2], first_rise [2], start_cyc [2], max_addr [2], cmd_err [2];
    int cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 2; i++) begin
            automatic logic ln   = e_act[i] && (e_cnt[i] < (e_bit[i] ? 7 : 3));
            automatic logic cons = a_wait[i] && (a_cmd[i] == 2'b01);
            if (mrst) begin
                e_act[i] <= 1'b0; e_cnt[i] <= 0; e_bit[i] <= 1'b0;
            end else if (cons) begin
                e_act[i] <= 1'b1; e_cnt[i] <= 0; e_bit[i] <= a_db[i];
            end else if (e_act[i]) begin
                if (e_cnt[i] == 10) e_act[i] <= 1'b0;
                else e_cnt[i] <= e_cnt[i] + 1;
            end
            if (clr[i]) begin
                cap[i] <= '0; nbits[i] <= 0; last_cons[i] <= 0; first_cons[i] <= -1;
                sp_err[i] <= 0; hi_err[i] <= 0; hi_run[i] <= 0; done_cnt[i] <= 0;
                last_fall[i] <= 0; gap[i] <= 0; first_rise[i] <= -1; max_addr[i] <= 0; cmd_err[i] <= 0;
                start_cyc[i] <= (a_start[i] && !a_busy[i]) ? cyc : -1;
            end else begin
                if (cons) begin
                    cap[i] <= {cap[i][62:0], a_db[i]};
                    nbits[i] <= nbits[i] + 1;
                    if (nbits[i] == 0) first_cons[i] <= cyc;
                    else if (cyc - last_cons[i] != 11) sp_err[i] <= sp_err[i] + 1;
                    last_cons[i] <= cyc;
                end
                if (ln) begin
                    if (hi_run[i] == 0 && first_rise[i] < 0) first_rise[i] <= cyc;
                    hi_run[i] <= hi_run[i] + 1;
                end else if (hi_run[i] != 0) begin
                    if (hi_run[i] != (e_bit[i] ? 7 : 3)) hi_err[i] <= hi_err[i] + 1;
                    hi_run[i] <= 0;
                    last_fall[i] <= cyc;
                end
                if (a_done[i]) begin
                    done_cnt[i] <= done_cnt[i] + 1;
                    gap[i] <= cyc - last_fall[i];
                end
                if (a_start[i] && !a_busy[i] && start_cyc[i] < 0) start_cyc[i] <= cyc;
                if (int'(a_addr[i]) > max_addr[i]) max_addr[i] <= int'(a_addr[i]);
                if (a_cmd[i][1]) cmd_err[i] <= cmd_err[i] + 1;
            end
        end
    end

    int tests = 0, fails = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_rng(input string nm, input int act, input int lo, input int hi);
        tests++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_done(input int i, input string nm);
        int k = 0;
        do begin
            tick();
            k++;
        end while (!a_done[i] && k < 4000);
        check({nm, "_done_seen"}, 64'(a_done[i]), 64'd1);
    endtask

    task automatic pulse_start(input int i);
        clr[i] = 1'b1; st[i] = 1'b1;
        tick();
        clr[i] = 1'b0; st[i] = 1'b0;
    endtask

    // returns at the negedge of the cycle following done
    task automatic finish_frame(input int i, input logic [63:0] exp, input int nb, input string nm);
        logic [63:0] mask;
        mask = (64'd1 << nb) - 64'd1;
        wait_done(i, nm);
        tick();
        check({nm, "_busy_after"}, 64'(a_busy[i]), 64'd0);
        check({nm, "_done_width"}, 64'(a_done[i]), 64'd0);
        check({nm, "_bits"}, cap[i] & mask, exp & mask);
        check({nm, "_nbits"}, 64'(nbits[i]), 64'(nb));
        check({nm, "_period"}, 64'(sp_err[i]), 64'd0);
        check({nm, "_hightime"}, 64'(hi_err[i]), 64'd0);
        check({nm, "_done_cnt"}, 64'(done_cnt[i]), 64'd1);
        check({nm, "_cmd10"}, 64'(cmd_err[i]), 64'd0);
        check_rng({nm, "_latch_gap"}, gap[i], 800, 820);
        check_rng({nm, "_tx_latency"}, first_cons[i] - start_cyc[i], 3, 3);
    endtask

    typedef struct {
        logic [23:0] p0;
        logic [23:0] p1;
        logic [47:0] exp;
    } vec_t;
    vec_t tv [4];

    initial begin
        int fall_sv, gap_sv, k;
        tv[0] = '{24'hFF0000, 24'h00AA55, 48'hFF0000_00AA55};
        tv[1] = '{24'h123456, 24'hABCDEF, 48'h123456_ABCDEF};
        tv[2] = '{24'h000000, 24'hFFFFFF, 48'h000000_FFFFFF};
        tv[3] = '{24'h800001, 24'h7FFFFE, 48'h800001_7FFFFE};

        rst_n = 1'b0; mrst = 1'b1;
        st[0] = 1'b0; st[1] = 1'b0; clr[0] = 1'b1; clr[1] = 1'b1;
        ram0[0] = 24'h0; ram0[1] = 24'h0; ram1 = 24'h0;
        tick(); tick();
        mrst = 1'b0;
        check("rst_busy0", 64'(busy0), 64'd0);
        check("rst_done0", 64'(done0), 64'd0);
        check("rst_addr0", 64'(pa0), 64'd0);
        check("rst_cmd0",  64'(cmd0), 64'd0);
        check("rst_bit0",  64'(db0), 64'd0);
        check("rst_busy1", 64'(busy1), 64'd0);
        check("rst_cmd1",  64'(cmd1), 64'd0);
        rst_n = 1'b1;
        tick();
        clr[0] = 1'b0; clr[1] = 1'b0;
        tick();

        for (int v = 0; v < 4; v++) begin
            ram0[0] = tv[v].p0; ram0[1] = tv[v].p1;
            pulse_start(0);
            finish_frame(0, 64'(tv[v].exp), 48, $sformatf("vec%0d", v));
        end

        // start pulsed mid-SEND and again in the done cycle
        ram0[0] = 24'hFF0000; ram0[1] = 24'h00AA55;
        pulse_start(0);
        repeat (200) tick();
        st[0] = 1'b1; tick(); st[0] = 1'b0;
        wait_done(0, "busy_start");
        st[0] = 1'b1; tick(); st[0] = 1'b0;
        repeat (20) tick();
        check("busy_start_idle", 64'(busy0), 64'd0);
        check("busy_start_nbits", 64'(nbits[0]), 64'd48);
        check("busy_start_done_cnt", 64'(done_cnt[0]), 64'd1);
        check("busy_start_bits", cap[0] & 64'hFFFF_FFFF_FFFF, 64'hFF0000_00AA55);

        // back-to-back frames: second start in the cycle after done
        pulse_start(0);
        finish_frame(0, 64'hFF0000_00AA55, 48, "b2b_a");
        fall_sv = last_fall[0]; gap_sv = gap[0];
        pulse_start(0);
        finish_frame(0, 64'hFF0000_00AA55, 48, "b2b_b");
        check_rng("b2b_low_time", first_rise[0] - fall_sv, gap_sv, gap_sv + 5);

        // reset during bit 5 of pixel 0
        pulse_start(0);
        k = 0;
        while (nbits[0] < 6 && k < 600) begin tick(); k++; end
        check("mid_rst_reached", 64'(nbits[0] >= 6), 64'd1);
        tick(); tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy0), 64'd0);
        check("mid_rst_cmd",  64'(cmd0), 64'd0);
        check("mid_rst_bit",  64'(db0), 64'd0);
        check("mid_rst_addr", 64'(pa0), 64'd0);
        check("mid_rst_done", 64'(done0), 64'd0);
        tick();
        rst_n = 1'b1;
        repeat (1000) tick();
        check("mid_rst_no_done", 64'(done_cnt[0]), 64'd0);
        pulse_start(0);
        finish_frame(0, 64'hFF0000_00AA55, 48, "after_rst");

        // single-pixel instance
        ram1 = 24'h800001;
        pulse_start(1);
        finish_frame(1, 64'h800001, 24, "single");
        check("single_max_addr", 64'(max_addr[1]), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
